// File: rtl/alu_arbiter_if.sv
// +--------------------------------------------------------------------+
// | alu_arbiter_if : requester, shared-ALU and response bus bundle     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             r0_valid;
  logic             r0_ready;
  logic [3:0]       r0_op;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;

  logic             r1_valid;
  logic             r1_ready;
  logic [3:0]       r1_op;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;

  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  logic             busy;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    output r0_ready,
    input  r1_valid, r1_op, r1_a, r1_b,
    output r1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_y,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    input  r0_ready,
    output r1_valid, r1_op, r1_a, r1_b,
    input  r1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_y,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------+
// | alu_arbiter : round-robin arbiter sharing one ALU between two      |
// | requesters, with fixed MUL/DIV latency and error reporting.        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MULDIV_LAT = 3
) (
  input  logic         clock,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] c_op_pass = 4'h2;
  localparam logic [3:0] c_op_add  = 4'h3;
  localparam logic [3:0] c_op_sub  = 4'h4;
  localparam logic [3:0] c_op_mul  = 4'h5;
  localparam logic [3:0] c_op_div  = 4'h6;
  localparam logic [3:0] c_op_and  = 4'h8;
  localparam logic [3:0] c_op_or   = 4'h9;
  localparam logic [3:0] c_op_xor  = 4'hA;
  localparam logic [3:0] c_op_shl  = 4'hE;
  localparam logic [3:0] c_op_shr  = 4'hF;

  // Counter counts remaining EXEC cycles beyond the final capture cycle.
  localparam logic [2:0] c_muldiv_cnt = 3'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      c_op_pass, c_op_add, c_op_sub, c_op_mul, c_op_div,
      c_op_and, c_op_or, c_op_xor, c_op_shl, c_op_shr: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant_id;
  logic             accept;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  // On a tie the requester that was not served last wins; otherwise the
  // lone valid requester is chosen.
  always_comb begin
    if (bus.r0_valid && bus.r1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = bus.r1_valid;
    end
  end

  assign bus.r0_ready = reset && (state_q == ST_IDLE) && bus.r0_valid && !grant_id;
  assign bus.r1_ready = reset && (state_q == ST_IDLE) && bus.r1_valid &&  grant_id;
  assign accept       = bus.r0_ready || bus.r1_ready;

  assign req_op = grant_id ? bus.r1_op : bus.r0_op;
  assign req_a  = grant_id ? bus.r1_a  : bus.r0_a;
  assign req_b  = grant_id ? bus.r1_b  : bus.r0_b;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d         = grant_id;
          last_grant_d = grant_id;
          op_d         = req_op;
          a_d          = req_a;
          b_d          = req_b;
          cnt_d        = ((req_op == c_op_mul) || (req_op == c_op_div)) ? c_muldiv_cnt : 3'd0;
          state_d      = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          // Divide-by-zero overrides whatever the ALU produced.
          if ((op_q == c_op_div) && (b_q == '0)) begin
            rsp_data_d = '1;
            rsp_err_d  = 1'b1;
          end else if (!is_legal(op_q)) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_data_d = bus.alu_y;
            rsp_err_d  = 1'b0;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      op_q         <= c_op_pass;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ALU operands come only from the latched request so they stay stable
  // for the whole operation and until the next accept.
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_alu_arbiter : directed table-driven bench for alu_arbiter       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int LAT   = 3;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] data;
    logic        err;
    string       name;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[14];

  alu_arbiter_if #(.WIDTH(WIDTH)) bus();

  alu_arbiter #(.WIDTH(WIDTH), .MULDIV_LAT(LAT)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Stand-in shared ALU; illegal codes and divide-by-zero return junk
  // that the arbiter must not forward.
  always_comb begin
    case (bus.alu_op)
      4'h2:    bus.alu_y = bus.alu_a;
      4'h3:    bus.alu_y = bus.alu_a + bus.alu_b;
      4'h4:    bus.alu_y = bus.alu_a - bus.alu_b;
      4'h5:    bus.alu_y = bus.alu_a * bus.alu_b;
      4'h6:    bus.alu_y = (bus.alu_b == 0) ? 32'h1234_5678 : bus.alu_a / bus.alu_b;
      4'h8:    bus.alu_y = bus.alu_a & bus.alu_b;
      4'h9:    bus.alu_y = bus.alu_a | bus.alu_b;
      4'hA:    bus.alu_y = bus.alu_a ^ bus.alu_b;
      4'hE:    bus.alu_y = bus.alu_a << bus.alu_b[4:0];
      4'hF:    bus.alu_y = bus.alu_a >> bus.alu_b[4:0];
      default: bus.alu_y = 32'hBAD0_BAD0;
    endcase
  end

  function automatic vec_t mk(input logic id, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int lat, input logic [31:0] data,
                              input logic err, input string name);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.lat = lat;
    v.data = data; v.err = err; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.r1_valid = v; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
    end else begin
      bus.r0_valid = v; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? bus.r1_ready : bus.r0_ready;
  endfunction

  // Present a request, wait (bounded) for its grant, then take the accept edge.
  task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    int w;
    set_req(id, 1'b1, op, a, b);
    #1;
    w = 0;
    while (!rdy(id) && w < 20) begin
      tick();
      w++;
    end
    check({name, "_grant"}, {31'd0, rdy(id)}, 32'd1);
    tick();
    set_req(id, 1'b0, op, a, b);
    #1;
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.rsp_valid && lat < 20);
  endtask

  task automatic finish_rsp(input string name);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_rsp_clr"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.id, v.op, v.a, v.b, v.name);
    wait_rsp(lat);
    check({v.name, "_lat"},  lat, v.lat);
    check({v.name, "_data"}, bus.rsp_data, v.data);
    check({v.name, "_err"},  {31'd0, bus.rsp_err}, {31'd0, v.err});
    check({v.name, "_id"},   {31'd0, bus.rsp_id}, {31'd0, v.id});
    finish_rsp(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;

    vecs[0]  = mk(1'b0, 4'h3, 32'd5,         32'd7,  1, 32'd12,        1'b0, "add");
    vecs[1]  = mk(1'b1, 4'h5, 32'd6,         32'd7,  3, 32'd42,        1'b0, "mul");
    vecs[2]  = mk(1'b0, 4'h6, 32'd9,         32'd0,  3, 32'hFFFF_FFFF, 1'b1, "div0");
    vecs[3]  = mk(1'b1, 4'h7, 32'd3,         32'd4,  1, 32'd0,         1'b1, "ill7");
    vecs[4]  = mk(1'b0, 4'h4, 32'd10,        32'd3,  1, 32'd7,         1'b0, "sub");
    vecs[5]  = mk(1'b1, 4'h8, 32'hF0,        32'h3C, 1, 32'h30,        1'b0, "and");
    vecs[6]  = mk(1'b0, 4'h9, 32'hF0,        32'h0F, 1, 32'hFF,        1'b0, "or");
    vecs[7]  = mk(1'b1, 4'hA, 32'hFF,        32'h0F, 1, 32'hF0,        1'b0, "xor");
    vecs[8]  = mk(1'b0, 4'hE, 32'd1,         32'd4,  1, 32'h10,        1'b0, "shl");
    vecs[9]  = mk(1'b1, 4'hF, 32'h80,        32'd3,  1, 32'h10,        1'b0, "shr");
    vecs[10] = mk(1'b0, 4'h2, 32'hDEAD_BEEF, 32'd9,  1, 32'hDEAD_BEEF, 1'b0, "pass");
    vecs[11] = mk(1'b1, 4'h6, 32'd100,       32'd7,  3, 32'd14,        1'b0, "div");
    vecs[12] = mk(1'b0, 4'h0, 32'd1,         32'd1,  1, 32'd0,         1'b1, "ill0");
    vecs[13] = mk(1'b1, 4'h3, 32'hFFFF_FFFF, 32'd1,  1, 32'd0,         1'b0, "add_wrap");

    set_req(1'b0, 1'b1, 4'h3, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 4'h3, 32'd2, 32'd2);
    bus.rsp_ready = 1'b0;

    // Reset state, with both requesters asserting throughout.
    repeat (3) tick();
    check("rst_r0_ready",  {31'd0, bus.r0_ready}, 32'd0);
    check("rst_r1_ready",  {31'd0, bus.r1_ready}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_id",    {31'd0, bus.rsp_id}, 32'd0);
    check("rst_rsp_data",  bus.rsp_data, 32'd0);
    check("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    check("rst_alu_op",    {28'd0, bus.alu_op}, 32'd2);
    check("rst_alu_a",     bus.alu_a, 32'd0);
    check("rst_alu_b",     bus.alu_b, 32'd0);

    // First tie after reset goes to requester 0, then requester 1.
    set_req(1'b0, 1'b1, 4'h4, 32'd20, 32'd5);
    set_req(1'b1, 1'b1, 4'h4, 32'd8,  32'd3);
    rst_n = 1'b1;
    #1;
    check("tie_r0_ready", {31'd0, bus.r0_ready}, 32'd1);
    check("tie_r1_ready", {31'd0, bus.r1_ready}, 32'd0);
    tick();
    bus.r0_valid = 1'b0;
    #1;
    check("tie_exec_r1_ready", {31'd0, bus.r1_ready}, 32'd0);
    wait_rsp(lat);
    check("tie0_lat",  lat, 1);
    check("tie0_id",   {31'd0, bus.rsp_id}, 32'd0);
    check("tie0_data", bus.rsp_data, 32'd15);
    check("tie_done_r1_ready", {31'd0, bus.r1_ready}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    check("tie_r1_granted", {31'd0, bus.r1_ready}, 32'd1);
    tick();
    bus.r1_valid = 1'b0;
    wait_rsp(lat);
    check("tie1_id",   {31'd0, bus.rsp_id}, 32'd1);
    check("tie1_data", bus.rsp_data, 32'd5);
    finish_rsp("tie1");

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
    end

    // After serving requester 0, a tie must go to requester 1.
    run_vec(mk(1'b0, 4'h3, 32'd2, 32'd2, 1, 32'd4, 1'b0, "rr_pre"));
    set_req(1'b0, 1'b1, 4'h3, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 4'h3, 32'd3, 32'd3);
    #1;
    check("rr_r1_ready", {31'd0, bus.r1_ready}, 32'd1);
    check("rr_r0_ready", {31'd0, bus.r0_ready}, 32'd0);
    tick();
    bus.r1_valid = 1'b0;
    wait_rsp(lat);
    check("rr1_data", bus.rsp_data, 32'd6);
    finish_rsp("rr1");
    bus.r0_valid = 1'b0;
    run_vec(mk(1'b0, 4'h3, 32'd1, 32'd1, 1, 32'd2, 1'b0, "rr0"));

    // Backpressure: response held for 5 cycles while requester 1 waits.
    issue(1'b0, 4'h5, 32'd3, 32'd4, "bp");
    set_req(1'b1, 1'b1, 4'h2, 32'h55, 32'd0);
    wait_rsp(lat);
    check("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",    {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_data",     bus.rsp_data, 32'd12);
      check("bp_id",       {31'd0, bus.rsp_id}, 32'd0);
      check("bp_err",      {31'd0, bus.rsp_err}, 32'd0);
      check("bp_r0_ready", {31'd0, bus.r0_ready}, 32'd0);
      check("bp_r1_ready", {31'd0, bus.r1_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_idle",     {31'd0, bus.busy}, 32'd0);
    check("bp_r1_ready", {31'd0, bus.r1_ready}, 32'd1);
    // Withdrawn request leaves no trace.
    bus.r1_valid = 1'b0;
    repeat (3) tick();
    check("withdraw_busy",   {31'd0, bus.busy}, 32'd0);
    check("withdraw_alu_op", {28'd0, bus.alu_op}, 32'd5);
    check("withdraw_alu_a",  bus.alu_a, 32'd3);

    // Reset during MUL EXEC discards the operation.
    issue(1'b1, 4'h5, 32'd6, 32'd7, "rstmid");
    rst_n = 1'b0;
    tick();
    check("rstmid_busy",   {31'd0, bus.busy}, 32'd0);
    check("rstmid_valid",  {31'd0, bus.rsp_valid}, 32'd0);
    check("rstmid_alu_op", {28'd0, bus.alu_op}, 32'd2);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid || bus.busy) seen = 1'b1;
    end
    bus.rsp_ready = 1'b0;
    check("rstmid_no_rsp", {31'd0, seen}, 32'd0);
    run_vec(mk(1'b1, 4'h3, 32'd40, 32'd2, 1, 32'd42, 1'b0, "post_rst"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter MULDIV_LAT, default 3, giving the EXEC cycles for MUL and DIV (legal range 1..7).
REQ-003 The block SHALL have these ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- r0_valid  in  1  requester 0 has an operation pending.
- r0_ready  out  1  requester 0 accepted this cycle.
- r0_op  in  4  requester 0 ALU opcode.
- r0_a, r0_b  in  WIDTH  requester 0 operands.
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same as requester 0, for requester 1.
- alu_op  out  4  opcode to the shared ALU.
- alu_a, alu_b  out  WIDTH  operands to the shared ALU.
- alu_y  in  WIDTH  shared ALU result (combinational).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  result.
- rsp_err  out  1  illegal opcode or divide by zero.
- busy  out  1  state is not IDLE.

Function
REQ-004 The opcode map SHALL be PASS=2, ADD=3, SUB=4, MUL=5, DIV=6, AND=8, OR=9, XOR=A, SHL=E, SHR=F; all other codes are illegal.
REQ-005 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-006 In IDLE, exactly one rN_ready SHALL be high: that of the granted requester, and only if its rN_valid is high. Both rN_ready outputs SHALL be low in EXEC and DONE.
REQ-007 Arbitration SHALL be round-robin:
- If both requesters are valid, grant the one not in last_grant.
- If only one is valid, grant it.
- last_grant updates on every accept.
REQ-008 An accept (rN_valid and rN_ready both high at a posedge) SHALL latch op, a, b and id into internal registers and move to EXEC.
REQ-009 At accept, the counter SHALL load MULDIV_LAT-1 for MUL/DIV and 0 for all other opcodes.
REQ-010 alu_op, alu_a and alu_b SHALL be driven only from the latched registers, so they stay stable from the accept edge until the next accept.
REQ-011 In EXEC, at each posedge:
- If the counter is nonzero, decrement it.
- If the counter is zero, capture the result, set rsp_valid=1 and move to DONE.
REQ-012 rsp_valid SHALL therefore rise 1 cycle after the accept edge for single-cycle ops and MULDIV_LAT cycles after it for MUL/DIV.
REQ-013 The captured result SHALL be:
- Legal opcode: rsp_data=alu_y, rsp_err=0.
- Illegal opcode: rsp_data=0, rsp_err=1.
- DIV with b==0: rsp_data=all-ones, rsp_err=1 (alu_y ignored).
REQ-014 rsp_id SHALL equal the latched requester id.
REQ-015 In DONE, rsp_valid, rsp_id, rsp_data and rsp_err SHALL hold until a posedge with rsp_ready=1; at that edge rsp_valid goes to 0 and the state goes to IDLE.
REQ-016 A new accept SHALL NOT occur in the same cycle as the response handshake, so minimum occupancy is lat+2 cycles per op.
REQ-017 If rN_valid drops before being granted, the request SHALL be ignored with no side effect.
REQ-018 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-019 busy SHALL be 1 in EXEC and DONE and 0 in IDLE.

Reset
REQ-020 While reset=0 at a posedge, the block SHALL set:
- state=IDLE, counter=0.
- last_grant=1, so requester 0 wins the first tie.
- rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
- latched op=PASS, latched a=0, latched b=0.
REQ-021 While reset=0, r0_ready and r1_ready SHALL be 0 combinationally.
REQ-022 A reset asserted in EXEC or DONE SHALL discard the operation, and no response SHALL be produced for it.

Verification
REQ-023 Single op, MULDIV_LAT=3: r0 ADD a=5 b=7 -> r0_ready high in IDLE; rsp_valid 1 cycle after accept; rsp_data=12, rsp_id=0, rsp_err=0.
REQ-024 Tie after reset: r0 and r1 both valid with SUB -> r0 granted first, r1 granted in the IDLE cycle following r0's response; rsp_id sequence 0,1.
REQ-025 Multi-cycle op, MULDIV_LAT=3: r1 MUL 6x7 -> busy for 3 EXEC cycles; rsp_valid 3 cycles after accept; rsp_data=42.
REQ-026 Error paths:
- DIV a=9 b=0 -> rsp_err=1, rsp_data=FFFFFFFF.
- op=4'h7 -> rsp_err=1, rsp_data=0.
REQ-027 Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp fields stable, r0_ready and r1_ready stay 0; rsp_ready=1 -> IDLE on the next edge.
REQ-028 Reset mid-operation: reset=0 during MUL EXEC -> next cycle state IDLE, rsp_valid=0, busy=0, and no response appears after release.
